// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and the latency counter width, plus the load extension helper.
package dmem_pkg;

  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  // Sign- or zero-extend a right-aligned byte (is_byte=1) or halfword to 32 bits.
  function automatic logic [31:0] f_extend(input logic [15:0] i_val,
                                           input logic        i_is_byte,
                                           input logic        i_is_unsigned);
    logic w_sign;
    if (i_is_byte) begin
      w_sign = ~i_is_unsigned & i_val[7];
      return {{24{w_sign}}, i_val[7:0]};
    end
    w_sign = ~i_is_unsigned & i_val[15];
    return {{16{w_sign}}, i_val[15:0]};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables/data, load
// extraction/extension and the misalign flag (DMEM_MISALIGN_ERR_EN).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  size_e       w_size;
  logic [1:0]  w_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

`ifdef DMEM_MISALIGN_ERR_EN
  always_comb begin
    w_size     = size_e'(i_size);
    w_off      = i_offset;
    o_misalign = (w_size == SZ_RSVD)
               | ((w_size == SZ_HALF) & i_offset[0])
               | ((w_size == SZ_WORD) & (i_offset != 2'b00));
  end
`else
  // Without fault reporting, offsets round down to natural alignment and the
  // reserved size behaves as a word access.
  always_comb begin
    w_size     = (size_e'(i_size) == SZ_RSVD) ? SZ_WORD : size_e'(i_size);
    o_misalign = 1'b0;
    case (w_size)
      SZ_BYTE: w_off = i_offset;
      SZ_HALF: w_off = {i_offset[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end
`endif

  always_comb begin
    w_byte = i_rword[7:0];
    case (w_off)
      2'd0: w_byte = i_rword[7:0];
      2'd1: w_byte = i_rword[15:8];
      2'd2: w_byte = i_rword[23:16];
      2'd3: w_byte = i_rword[31:24];
      default: w_byte = i_rword[7:0];
    endcase
  end

  assign w_half = w_off[1] ? i_rword[31:16] : i_rword[15:0];

  // Store data is replicated across lanes so the byte enable alone picks the target.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0000_0000;
    o_rdata = 32'h0000_0000;
    case (w_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << w_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = f_extend({8'h00, w_byte}, 1'b1, i_unsigned);
      end
      SZ_HALF: begin
        o_be    = w_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = f_extend(w_half, 1'b0, i_unsigned);
      end
      SZ_WORD: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
        o_rdata = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory with valid/ready request/response handshake and fixed access
// latency; misaligned-access faults are enabled by DMEM_MISALIGN_ERR_EN.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]          r_mem [DEPTH_WORDS];
  state_e               r_state;
  state_e               w_state_nxt;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic [LAT_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]          r_rdata;
  logic                 r_err;

  logic [IDX_W-1:0]     w_idx;
  logic                 w_accept;
  logic                 w_wr_en;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic [31:0]          w_load;
  logic                 w_misalign;

  // Address bits above the array size alias onto the same words.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^i_req_addr[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  assign w_idx       = i_req_addr[IDX_W+1:2];
  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_wr_en     = w_accept & i_req_we & ~w_misalign;

  dmem_lane_align u_lane (
    .i_size     (i_req_size),
    .i_offset   (i_req_addr[1:0]),
    .i_unsigned (i_req_unsigned),
    .i_wdata    (i_req_wdata),
    .i_rword    (r_mem[w_idx]),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_load),
    .o_misalign (w_misalign)
  );

  // The array has no reset so a store committed before reset survives it.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rdata <= (i_req_we | w_misalign) ? 32'h0000_0000 : w_load;
        r_err   <= w_misalign;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY > 1) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LAT_CNT_W'(LATENCY - 1);
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt <= LAT_CNT_W'(1)) begin
          w_state_nxt = S_RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - LAT_CNT_W'(1);
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl: one instance at LATENCY=1,
// one at LATENCY=4; expectations follow DMEM_MISALIGN_ERR_EN when defined.
module tb_data_mem_ctrl;

  localparam logic [1:0] SZB = 2'b00;
  localparam logic [1:0] SZH = 2'b01;
  localparam logic [1:0] SZW = 2'b10;
  localparam logic [1:0] SZR = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        reqWe, reqUnsigned;
  logic [31:0] reqAddr, reqWdata;
  logic [1:0]  reqSize;
  logic        reqValid0, reqValid1, rspReady0, rspReady1;
  logic        reqReady0, reqReady1, rspValid0, rspValid1, rspErr0, rspErr1;
  logic [31:0] rspRdata0, rspRdata1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .ADDR_W(32), .LATENCY(1)) dutFast (
    .i_clk(clock), .i_reset(reset), .i_req_valid(reqValid0), .o_req_ready(reqReady0),
    .i_req_we(reqWe), .i_req_addr(reqAddr), .i_req_wdata(reqWdata), .i_req_size(reqSize),
    .i_req_unsigned(reqUnsigned), .o_rsp_valid(rspValid0), .i_rsp_ready(rspReady0),
    .o_rsp_rdata(rspRdata0), .o_rsp_err(rspErr0)
  );

  data_mem_ctrl #(.DEPTH_WORDS(1024), .ADDR_W(32), .LATENCY(4)) dutSlow (
    .i_clk(clock), .i_reset(reset), .i_req_valid(reqValid1), .o_req_ready(reqReady1),
    .i_req_we(reqWe), .i_req_addr(reqAddr), .i_req_wdata(reqWdata), .i_req_size(reqSize),
    .i_req_unsigned(reqUnsigned), .o_rsp_valid(rspValid1), .i_rsp_ready(rspReady1),
    .o_rsp_rdata(rspRdata1), .o_rsp_err(rspErr1)
  );

  function automatic logic rdyOf(input int d);
    return (d == 0) ? reqReady0 : reqReady1;
  endfunction

  function automatic logic rvOf(input int d);
    return (d == 0) ? rspValid0 : rspValid1;
  endfunction

  function automatic logic [31:0] rdataOf(input int d);
    return (d == 0) ? rspRdata0 : rspRdata1;
  endfunction

  function automatic logic errOf(input int d);
    return (d == 0) ? rspErr0 : rspErr1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic setValid(input int d, input logic v);
    if (d == 0) reqValid0 = v;
    else        reqValid1 = v;
  endtask

  task automatic setReady(input int d, input logic v);
    if (d == 0) rspReady0 = v;
    else        rspReady1 = v;
  endtask

  task automatic startAccess(input string tag, input int d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    int n = 0;
    while (!rdyOf(d) && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput({tag, ".reqReady"}, {31'd0, rdyOf(d)}, 32'd1);
    reqWe = we; reqAddr = addr; reqWdata = wdata; reqSize = size; reqUnsigned = uns;
    setValid(d, 1'b1);
    @(posedge clock); #1;
    setValid(d, 1'b0);
  endtask

  // Full transaction: accept, measure latency, optionally stall the response, handshake.
  task automatic applyStimulus(input string tag, input int d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                               input logic [31:0] expRdata, input logic expErr, input int expLat,
                               input int hold);
    int lat;
    startAccess(tag, d, we, addr, wdata, size, uns);
    lat = 1;
    while (!rvOf(d) && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".rdata"}, rdataOf(d), expRdata);
    checkOutput({tag, ".err"}, {31'd0, errOf(d)}, {31'd0, expErr});
    checkOutput({tag, ".busy"}, {31'd0, rdyOf(d)}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      checkOutput({tag, ".holdValid"}, {31'd0, rvOf(d)}, 32'd1);
      checkOutput({tag, ".holdRdata"}, rdataOf(d), expRdata);
      checkOutput({tag, ".holdErr"}, {31'd0, errOf(d)}, {31'd0, expErr});
      checkOutput({tag, ".holdBusy"}, {31'd0, rdyOf(d)}, 32'd0);
    end
    setReady(d, 1'b1);
    @(posedge clock); #1;
    setReady(d, 1'b0);
    checkOutput({tag, ".validDrop"}, {31'd0, rvOf(d)}, 32'd0);
    checkOutput({tag, ".readyBack"}, {31'd0, rdyOf(d)}, 32'd1);
  endtask

  initial begin
    logic [31:0] misStoreErrRd, misWordAfter, rsvdRd, offWordRd, oddHalfRd;
    logic        misErr;
    logic        sawValid;

`ifdef DMEM_MISALIGN_ERR_EN
    misErr = 1'b1;
    misStoreErrRd = 32'h0000_0000;
    misWordAfter  = 32'h001D_3344;
    rsvdRd        = 32'h0000_0000;
    offWordRd     = 32'h0000_0000;
    oddHalfRd     = 32'h0000_0000;
`else
    misErr = 1'b0;
    misStoreErrRd = 32'h0000_0000;
    misWordAfter  = 32'hABCD_3344;
    rsvdRd        = 32'hDEAD_BEEF;
    offWordRd     = 32'hDEAD_BEEF;
    oddHalfRd     = 32'hFFFF_BEEF;
`endif

    reset = 1'b1;
    reqValid0 = 1'b0; reqValid1 = 1'b0; rspReady0 = 1'b0; rspReady1 = 1'b0;
    reqWe = 1'b0; reqAddr = '0; reqWdata = '0; reqSize = SZW; reqUnsigned = 1'b0;
    #3;
    checkOutput("reset.reqReady", {31'd0, reqReady0}, 32'd1);
    checkOutput("reset.rspValid", {31'd0, rspValid0}, 32'd0);
    checkOutput("reset.rspRdata", rspRdata0, 32'd0);
    checkOutput("reset.rspErr", {31'd0, rspErr0}, 32'd0);
    checkOutput("reset.slowReady", {31'd0, reqReady1}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;

    // LATENCY=1 word round trip and address wrap
    applyStimulus("stWord10",  0, 1'b1, 32'h10, 32'hDEADBEEF, SZW, 1'b0, 32'h0, 1'b0, 1, 0);
    applyStimulus("ldWord10",  0, 1'b0, 32'h10, 32'h0, SZW, 1'b0, 32'hDEADBEEF, 1'b0, 1, 0);
    applyStimulus("ldWrap",    0, 1'b0, 32'h8000_1010, 32'h0, SZW, 1'b1, 32'hDEADBEEF, 1'b0, 1, 0);

    // byte store and sign/zero extended loads
    applyStimulus("stWord20",  0, 1'b1, 32'h20, 32'h0, SZW, 1'b0, 32'h0, 1'b0, 1, 0);
    applyStimulus("stByte21",  0, 1'b1, 32'h21, 32'h1234_5680, SZB, 1'b0, 32'h0, 1'b0, 1, 0);
    applyStimulus("ldByteS21", 0, 1'b0, 32'h21, 32'h0, SZB, 1'b0, 32'hFFFF_FF80, 1'b0, 1, 0);
    applyStimulus("ldByteU21", 0, 1'b0, 32'h21, 32'h0, SZB, 1'b1, 32'h0000_0080, 1'b0, 1, 0);
    applyStimulus("ldWord20",  0, 1'b0, 32'h20, 32'h0, SZW, 1'b0, 32'h0000_8000, 1'b0, 1, 0);
    applyStimulus("ldHalfS20", 0, 1'b0, 32'h20, 32'h0, SZH, 1'b0, 32'hFFFF_8000, 1'b0, 1, 0);
    applyStimulus("ldHalfU20", 0, 1'b0, 32'h20, 32'h0, SZH, 1'b1, 32'h0000_8000, 1'b0, 1, 0);

    // halfword merge into an existing word
    applyStimulus("stWord00",  0, 1'b1, 32'h00, 32'h1122_3344, SZW, 1'b0, 32'h0, 1'b0, 1, 0);
    applyStimulus("stHalf02",  0, 1'b1, 32'h02, 32'hFFFF_001D, SZH, 1'b0, 32'h0, 1'b0, 1, 0);
    applyStimulus("ldWord00",  0, 1'b0, 32'h00, 32'h0, SZW, 1'b0, 32'h001D_3344, 1'b0, 1, 0);
    applyStimulus("ldHalfS00", 0, 1'b0, 32'h00, 32'h0, SZH, 1'b0, 32'h0000_3344, 1'b0, 1, 0);
    applyStimulus("ldHalfS02", 0, 1'b0, 32'h02, 32'h0, SZH, 1'b0, 32'h0000_001D, 1'b0, 1, 0);
    applyStimulus("ldByteS01", 0, 1'b0, 32'h01, 32'h0, SZB, 1'b0, 32'h0000_0033, 1'b0, 1, 0);
    applyStimulus("ldByteS03", 0, 1'b0, 32'h03, 32'h0, SZB, 1'b0, 32'h0000_0000, 1'b0, 1, 0);

    // misaligned and reserved-size accesses
    applyStimulus("stHalf03",  0, 1'b1, 32'h03, 32'h0000_ABCD, SZH, 1'b0, misStoreErrRd, misErr, 1, 0);
    applyStimulus("ldWordChk", 0, 1'b0, 32'h00, 32'h0, SZW, 1'b0, misWordAfter, 1'b0, 1, 0);
    applyStimulus("ldRsvd10",  0, 1'b0, 32'h10, 32'h0, SZR, 1'b0, rsvdRd, misErr, 1, 0);
    applyStimulus("ldWord12",  0, 1'b0, 32'h12, 32'h0, SZW, 1'b0, offWordRd, misErr, 1, 0);
    applyStimulus("ldHalf11",  0, 1'b0, 32'h11, 32'h0, SZH, 1'b0, oddHalfRd, misErr, 1, 0);

    // LATENCY=4 with response backpressure
    applyStimulus("slowSt40",  1, 1'b1, 32'h40, 32'hCAFE_F00D, SZW, 1'b0, 32'h0, 1'b0, 4, 3);
    applyStimulus("slowLd40",  1, 1'b0, 32'h40, 32'h0, SZW, 1'b0, 32'hCAFE_F00D, 1'b0, 4, 3);
    applyStimulus("slowLdB43", 1, 1'b0, 32'h43, 32'h0, SZB, 1'b0, 32'hFFFF_FFCA, 1'b0, 4, 0);

    // reset while the store response is still pending
    startAccess("rstWait", 1, 1'b1, 32'h44, 32'h1234_5678, SZW, 1'b0);
    @(posedge clock); #1;
    checkOutput("rstWait.noValid", {31'd0, rspValid1}, 32'd0);
    checkOutput("rstWait.busy", {31'd0, reqReady1}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rstWait.readyNow", {31'd0, reqReady1}, 32'd1);
    checkOutput("rstWait.validLow", {31'd0, rspValid1}, 32'd0);
    #2;
    reset = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (rspValid1) sawValid = 1'b1;
    end
    checkOutput("rstWait.neverValid", {31'd0, sawValid}, 32'd0);
    applyStimulus("rstWaitLd", 1, 1'b0, 32'h44, 32'h0, SZW, 1'b0, 32'h1234_5678, 1'b0, 4, 0);
    applyStimulus("fastAfter", 0, 1'b0, 32'h10, 32'h0, SZW, 1'b0, 32'hDEADBEEF, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
